// File: rtl/wb_stage.sv
// Writeback stage: buffers completed ALU/load results in a small FIFO, extracts load data,
// and drives the register file write port with backpressure and hazard reporting to ID.
module wb_stage #(
  parameter int DEPTH    = 2,
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4:0]          in_rd_addr,
  input  logic                in_rd_we,
  input  logic                in_is_load,
  input  logic [2:0]          in_funct3,
  input  logic [1:0]          in_byte_off,
  input  logic [31:0]         in_result,
  input  logic                flush,
  input  logic                wr_ready,
  output logic                rd_we,
  output logic [4:0]          rd_addr,
  output logic [31:0]         rd_wdata,
  input  logic [4:0]          q_rs1_addr,
  input  logic [4:0]          q_rs2_addr,
  output logic                rs1_pending,
  output logic                rs2_pending,
  output logic                load_err,
  output logic [RETIRE_W-1:0] retired_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [4:0]  addr;
    logic        wen;
    logic        err;
    logic [31:0] data;
  } entry_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  entry_t          out_q;
  logic            out_valid;
  logic [RETIRE_W-1:0] retired;

  entry_t      in_entry;
  logic [31:0] shifted;
  logic        push;
  logic        pop;
  logic        commit;

  assign shifted = in_result >> {in_byte_off, 3'b000};

  // Results are fully formed at push time so the FIFO and output register only carry
  // what the register file needs.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    in_entry      = '0;
    in_entry.addr = in_rd_addr;
    in_entry.data = in_result;
    if (in_is_load) begin
      unique case (in_funct3)
        F3_LB:   in_entry.data = {{24{shifted[7]}}, shifted[7:0]};
        F3_LBU:  in_entry.data = {24'd0, shifted[7:0]};
        F3_LH:   begin
                   in_entry.data = {{16{shifted[15]}}, shifted[15:0]};
                   in_entry.err  = in_byte_off[0];
                 end
        F3_LHU:  begin
                   in_entry.data = {16'd0, shifted[15:0]};
                   in_entry.err  = in_byte_off[0];
                 end
        F3_LW:   in_entry.err = (in_byte_off != 2'd0);
        default: in_entry.err = 1'b1;
      endcase
    end
    in_entry.wen = in_rd_we && (in_rd_addr != 5'd0) && !in_entry.err;
  end

  // Acceptance looks only at the registered count, so a full FIFO never accepts
  // even when the head is popping on the same edge.
  assign in_ready = rst && (count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign commit   = out_valid && (wr_ready || !out_q.wen);
  assign pop      = (count != '0) && (!out_valid || commit);

  // NOTE: the FIFO storage is deliberately not reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
      retired   <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (pop) begin
        out_q     <= mem[rd_ptr];
        out_valid <= 1'b1;
      end else if (commit) begin
        out_valid <= 1'b0;
      end
      if (commit) retired <= retired + RETIRE_W'(1);
    end
  end

  assign rd_we         = out_valid && out_q.wen;
  assign rd_addr       = out_q.addr;
  assign rd_wdata      = out_q.data;
  assign load_err      = out_valid && out_q.err;
  assign retired_count = retired;

  // A register is pending while any not-yet-committed entry would still write it.
  always_comb begin
    rs1_pending = 1'b0;
    rs2_pending = 1'b0;
    if (out_valid && out_q.wen) begin
      if (out_q.addr == q_rs1_addr) rs1_pending = 1'b1;
      if (out_q.addr == q_rs2_addr) rs2_pending = 1'b1;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count) && mem[rd_ptr + PW'(k)].wen) begin
        if (mem[rd_ptr + PW'(k)].addr == q_rs1_addr) rs1_pending = 1'b1;
        if (mem[rd_ptr + PW'(k)].addr == q_rs2_addr) rs2_pending = 1'b1;
      end
    end
    if (q_rs1_addr == 5'd0) rs1_pending = 1'b0;
    if (q_rs2_addr == 5'd0) rs2_pending = 1'b0;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus randomized traffic, all checked against a
// queue-based reference of the stage (FIFO queue + one output slot) kept in the bench.
module tb_wb_stage;
  localparam int DEPTH    = 2;
  localparam int RETIRE_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, in_rd_we = 1'b0, in_is_load = 1'b0, flush = 1'b0, wr_ready = 1'b0;
  logic [4:0]  in_rd_addr = '0, q_rs1_addr = '0, q_rs2_addr = '0;
  logic [2:0]  in_funct3 = '0;
  logic [1:0]  in_byte_off = '0;
  logic [31:0] in_result = '0;
  logic        in_ready, rd_we, rs1_pending, rs2_pending, load_err;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic [RETIRE_W-1:0] retired_count;

  always #5 clk = ~clk;

  wb_stage #(.DEPTH(DEPTH), .RETIRE_W(RETIRE_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we), .in_is_load(in_is_load),
    .in_funct3(in_funct3), .in_byte_off(in_byte_off), .in_result(in_result),
    .flush(flush), .wr_ready(wr_ready),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .q_rs1_addr(q_rs1_addr), .q_rs2_addr(q_rs2_addr),
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
    .load_err(load_err), .retired_count(retired_count)
  );

  typedef struct {
    logic [4:0]  addr;
    bit          wen;
    bit          err;
    logic [31:0] data;
  } ent_t;

  ent_t        fifo_q[$];
  ent_t        or_e;
  bit          or_v = 1'b0;
  logic [RETIRE_W-1:0] retired_m = '0;
  logic [4:0]  wlog[$];
  int          total = 0;
  int          bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected entry straight from the load/ALU rules, using arithmetic on the word.
  function automatic ent_t make_ent();
    ent_t e;
    logic [31:0] w;
    e.addr = in_rd_addr;
    e.err  = 1'b0;
    e.data = in_result;
    w = in_result >> (8 * int'(in_byte_off));
    if (in_is_load) begin
      case (in_funct3)
        3'd0: e.data = 32'($signed(w[7:0]));
        3'd4: e.data = 32'(w[7:0]);
        3'd1: begin e.err = in_byte_off[0]; e.data = 32'($signed(w[15:0])); end
        3'd5: begin e.err = in_byte_off[0]; e.data = 32'(w[15:0]); end
        3'd2: e.err = (in_byte_off != 0);
        default: e.err = 1'b1;
      endcase
    end
    e.wen = in_rd_we && (in_rd_addr != 0) && !e.err;
    return e;
  endfunction

  function automatic bit pend_m(input logic [4:0] q);
    if (q == 0) return 1'b0;
    if (or_v && or_e.wen && or_e.addr == q) return 1'b1;
    foreach (fifo_q[i]) if (fifo_q[i].wen && fifo_q[i].addr == q) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin : model
    bit   commit, pop, push;
    ent_t incoming;
    incoming = make_ent();
    push = in_valid && rst && (fifo_q.size() != DEPTH);
    if (rst && !flush && rd_we && wr_ready) wlog.push_back(rd_addr);
    if (!rst) begin
      fifo_q.delete();
      or_v = 1'b0;
      retired_m = '0;
    end else if (flush) begin
      fifo_q.delete();
      or_v = 1'b0;
    end else begin
      commit = or_v && (wr_ready || !or_e.wen);
      pop    = (fifo_q.size() != 0) && (!or_v || commit);
      if (commit) retired_m = retired_m + 1'b1;
      if (pop) begin
        or_e = fifo_q.pop_front();
        or_v = 1'b1;
      end else if (commit) begin
        or_v = 1'b0;
      end
      if (push) fifo_q.push_back(incoming);
    end
  end

  task automatic check_all();
    check("in_ready", in_ready, rst && (fifo_q.size() != DEPTH));
    check("rd_we", rd_we, or_v && or_e.wen);
    if (or_v && or_e.wen) begin
      check("rd_addr", rd_addr, or_e.addr);
      check("rd_wdata", rd_wdata, or_e.data);
    end
    check("load_err", load_err, or_v && or_e.err);
    check("rs1_pending", rs1_pending, pend_m(q_rs1_addr));
    check("rs2_pending", rs2_pending, pend_m(q_rs2_addr));
    check("retired", retired_count, retired_m);
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_in(input logic [4:0] a, input logic we, input logic ld,
                        input logic [2:0] f3, input logic [1:0] off, input logic [31:0] res);
    in_valid = 1'b1; in_rd_addr = a; in_rd_we = we; in_is_load = ld;
    in_funct3 = f3; in_byte_off = off; in_result = res;
  endtask

  task automatic push_one(input logic [4:0] a, input logic we, input logic ld,
                          input logic [2:0] f3, input logic [1:0] off, input logic [31:0] res);
    set_in(a, we, ld, f3, off, res);
    cyc();
    in_valid = 1'b0;
    cyc();
  endtask

  // Offer entries base, base+1, ... for a fixed number of cycles; returns how many were taken.
  task automatic offer_n(input int n, input int base, input int cycles, inout int k);
    for (int c = 0; c < cycles; c++) begin
      bit acc;
      if (k < n) set_in(5'(base + k), 1'b1, 1'b0, 3'd0, 2'd0, 32'(32'hA000 + base + k));
      else in_valid = 1'b0;
      acc = in_valid && in_ready;
      cyc();
      if (acc) k++;
    end
    in_valid = 1'b0;
  endtask

  logic [2:0]  t2_f3  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd0};
  logic [1:0]  t2_off [5] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd0};
  logic [31:0] t2_exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h00000001};

  initial begin
    int k;
    // Reset
    rst = 1'b0;
    repeat (3) cyc();
    check("rst_rd_addr", rd_addr, 0);
    check("rst_rd_wdata", rd_wdata, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_retired", retired_count, 0);
    rst = 1'b1;
    wr_ready = 1'b1;

    // T1: three back-to-back ALU writes
    wlog.delete();
    set_in(5'd1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h11); cyc();
    set_in(5'd2, 1'b1, 1'b0, 3'd0, 2'd0, 32'h22); cyc();
    check("t1_w1", {rd_we, rd_addr, rd_wdata}, {1'b1, 5'd1, 32'h11});
    set_in(5'd3, 1'b1, 1'b0, 3'd0, 2'd0, 32'h33); cyc();
    check("t1_w2", {rd_we, rd_addr, rd_wdata}, {1'b1, 5'd2, 32'h22});
    in_valid = 1'b0; cyc();
    check("t1_w3", {rd_we, rd_addr, rd_wdata}, {1'b1, 5'd3, 32'h33});
    cyc(); cyc();
    check("t1_retired", retired_count, 3);
    check("t1_nwrites", wlog.size(), 3);

    // T2: load extraction
    for (int i = 0; i < 5; i++) begin
      push_one(5'd10, 1'b1, 1'b1, t2_f3[i], t2_off[i], 32'h80FF7F01);
      check("t2_we", rd_we, 1);
      check("t2_data", rd_wdata, t2_exp[i]);
      cyc();
    end

    // T3: misaligned LW and illegal funct3
    push_one(5'd5, 1'b1, 1'b1, 3'b010, 2'd1, 32'hDEADBEEF);
    check("t3_we", rd_we, 0);
    check("t3_err", load_err, 1);
    cyc();
    check("t3_err_end", load_err, 0);
    check("t3_retired", retired_count, 9);
    push_one(5'd6, 1'b1, 1'b1, 3'b011, 2'd0, 32'h12345678);
    check("t3b_we", rd_we, 0);
    check("t3b_err", load_err, 1);
    cyc();
    check("t3b_err_end", load_err, 0);
    check("t3b_retired", retired_count, 10);

    // T4: x0 writes and pending hazard
    q_rs1_addr = 5'd0;
    push_one(5'd0, 1'b1, 1'b0, 3'd0, 2'd0, 32'h1234);
    check("t4_x0_we", rd_we, 0);
    check("t4_x0_pend", rs1_pending, 0);
    cyc();
    wr_ready = 1'b0;
    q_rs1_addr = 5'd7;
    set_in(5'd7, 1'b1, 1'b0, 3'd0, 2'd0, 32'h77); cyc();
    check("t4_pend_fifo", rs1_pending, 1);
    in_valid = 1'b0;
    repeat (3) cyc();
    check("t4_pend_or", rs1_pending, 1);
    wr_ready = 1'b1; cyc();
    check("t4_pend_clear", rs1_pending, 0);
    check("t4_retired", retired_count, 12);

    // T5: backpressure with four offered entries
    wlog.delete();
    wr_ready = 1'b0;
    k = 0;
    offer_n(4, 21, 8, k);
    check("t5_accepted", k, 3);
    check("t5_in_ready", in_ready, 0);
    check("t5_hold", {rd_we, rd_addr, rd_wdata}, {1'b1, 5'd21, 32'hA015});
    wr_ready = 1'b1;
    offer_n(4, 21, 10, k);
    check("t5_accepted_all", k, 4);
    check("t5_nwrites", wlog.size(), 4);
    for (int i = 0; i < 4; i++) check("t5_order", wlog[i], 21 + i);
    check("t5_retired", retired_count, 16);

    // T6: flush, then reset, with the stage full
    wr_ready = 1'b0;
    q_rs1_addr = 5'd25; q_rs2_addr = 5'd27;
    k = 0; offer_n(3, 25, 5, k);
    check("t6_full_pend1", rs1_pending, 1);
    check("t6_full_pend2", rs2_pending, 1);
    check("t6_full_ready", in_ready, 0);
    flush = 1'b1; set_in(5'd9, 1'b1, 1'b0, 3'd0, 2'd0, 32'h99); cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("t6_fl_we", rd_we, 0);
    check("t6_fl_pend", {rs1_pending, rs2_pending}, 0);
    check("t6_fl_ready", in_ready, 1);
    check("t6_fl_retired", retired_count, 16);
    cyc();
    check("t6_fl_idle", rd_we, 0);
    k = 0; offer_n(3, 25, 5, k);
    rst = 1'b0; cyc();
    check("t6_rst_we", rd_we, 0);
    check("t6_rst_pend", {rs1_pending, rs2_pending}, 0);
    check("t6_rst_ready", in_ready, 0);
    check("t6_rst_retired", retired_count, 0);
    rst = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_rd_addr  = 5'($urandom_range(0, 7));
      in_rd_we    = ($urandom_range(0, 7) != 0);
      in_is_load  = $urandom_range(0, 1) != 0;
      in_funct3   = 3'($urandom);
      in_byte_off = 2'($urandom);
      in_result   = $urandom;
      wr_ready    = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 49) == 0);
      rst         = ($urandom_range(0, 199) != 0);
      q_rs1_addr  = 5'($urandom_range(0, 7));
      q_rs2_addr  = 5'($urandom_range(0, 7));
      cyc();
    end
    in_valid = 1'b0; flush = 1'b0; rst = 1'b1; wr_ready = 1'b1;
    repeat (10) cyc();
    check("drain_we", rd_we, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
